// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data load/store.
// Data requests win unless a waiting fetch has already been passed over MAX_DATA_STREAK times.
module mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  input  logic              dm_req_we,
  input  logic [2:0]        dm_req_fn3,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [2:0]        mem_fn3,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_streak;
  logic              r_owner_dm;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic [2:0]        r_mem_fn3;
  logic              r_if_rsp_valid;
  logic              r_dm_rsp_valid;
  logic [DATA_W-1:0] r_if_rsp_data;
  logic [DATA_W-1:0] r_dm_rsp_data;

  logic w_idle;
  logic w_streak_full;
  logic w_dm_ready;
  logic w_if_ready;
  logic w_if_hs;
  logic w_dm_hs;

  // A lone fetch must still win; otherwise DM owns the slot unless the streak is exhausted.
  assign w_idle        = rst_n && (r_state == IDLE);
  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_dm_ready    = w_idle && !(if_req_valid && (w_streak_full || !dm_req_valid));
  assign w_if_ready    = w_idle && !w_dm_ready;
  assign w_if_hs       = if_req_valid && w_if_ready;
  assign w_dm_hs       = dm_req_valid && w_dm_ready;

  assign if_req_ready  = w_if_ready;
  assign dm_req_ready  = w_dm_ready;
  assign mem_req_valid = (r_state == ISSUE);
  assign busy          = (r_state != IDLE);
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_we        = r_mem_we;
  assign mem_fn3       = r_mem_fn3;
  assign if_rsp_valid  = r_if_rsp_valid;
  assign dm_rsp_valid  = r_dm_rsp_valid;
  assign if_rsp_data   = r_if_rsp_data;
  assign dm_rsp_data   = r_dm_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_streak       <= '0;
      r_owner_dm     <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_we       <= 1'b0;
      r_mem_fn3      <= 3'b000;
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_dm_rsp_data  <= '0;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_if_hs) begin
            r_mem_addr  <= if_req_addr;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_fn3   <= 3'b010;
            r_owner_dm  <= 1'b0;
            r_streak    <= '0;
            r_state     <= ISSUE;
          end else if (w_dm_hs) begin
            r_mem_addr  <= dm_req_addr;
            r_mem_wdata <= dm_req_wdata;
            r_mem_we    <= dm_req_we;
            r_mem_fn3   <= dm_req_fn3;
            r_owner_dm  <= 1'b1;
            if (if_req_valid && !w_streak_full) r_streak <= r_streak + 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
            if (r_owner_dm) begin
              r_dm_rsp_valid <= 1'b1;
              r_dm_rsp_data  <= r_mem_we ? '0 : mem_rsp_data;
            end else begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_data  <= mem_rsp_data;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_valid = 1'b0, if_req_ready;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          dm_req_valid = 1'b0, dm_req_ready;
  logic [AW-1:0] dm_req_addr = '0;
  logic [DW-1:0] dm_req_wdata = '0;
  logic          dm_req_we = 1'b0;
  logic [2:0]    dm_req_fn3 = 3'b000;
  logic          dm_rsp_valid;
  logic [DW-1:0] dm_rsp_data;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [2:0]    mem_fn3;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_we(dm_req_we), .dm_req_fn3(dm_req_fn3),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_fn3(mem_fn3),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  string grants = "";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_grants(input string name, input string exp);
    n_vec++;
    if (grants != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", name, grants, exp);
    end
  endtask

  // Model: one outstanding transaction record plus response registers.
  bit            m_busy, m_acc, m_own_dm, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [2:0]    m_fn3;
  int            m_streak;
  bit            m_if_rv, m_dm_rv;
  logic [DW-1:0] m_if_d, m_dm_d;

  always @(negedge clk) begin : cmp
    bit idle, e_dm, e_if, nif, ndm;
    #1;
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_own_dm = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_fn3 = '0; m_streak = 0;
      m_if_rv = 0; m_dm_rv = 0; m_if_d = '0; m_dm_d = '0;
    end
    idle = rst_n && !m_busy;
    if (!if_req_valid) e_dm = idle;
    else               e_dm = idle && dm_req_valid && (m_streak < MAXS);
    e_if = idle && !e_dm;

    chk("if_req_ready", if_req_ready, e_if);
    chk("dm_req_ready", dm_req_ready, e_dm);
    chk("one_ready", ($countones({if_req_ready, dm_req_ready}) <= 1), 1);
    chk("mem_req_valid", mem_req_valid, m_busy && !m_acc);
    chk("busy", busy, m_busy);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_we", mem_we, m_we);
    chk("mem_fn3", mem_fn3, m_fn3);
    chk("if_rsp_valid", if_rsp_valid, m_if_rv);
    chk("dm_rsp_valid", dm_rsp_valid, m_dm_rv);
    chk("if_rsp_data", if_rsp_data, m_if_d);
    chk("dm_rsp_data", dm_rsp_data, m_dm_d);

    if (rst_n && if_req_valid && if_req_ready) grants = {grants, "I"};
    if (rst_n && dm_req_valid && dm_req_ready) grants = {grants, "D"};

    if (rst_n) begin
      nif = 0; ndm = 0;
      if (!m_busy) begin
        if (if_req_valid && e_if) begin
          m_busy = 1; m_acc = 0; m_own_dm = 0;
          m_addr = if_req_addr; m_wdata = '0; m_we = 0; m_fn3 = 3'b010;
          m_streak = 0;
        end else if (dm_req_valid && e_dm) begin
          m_busy = 1; m_acc = 0; m_own_dm = 1;
          m_addr = dm_req_addr; m_wdata = dm_req_wdata; m_we = dm_req_we; m_fn3 = dm_req_fn3;
          if (if_req_valid && m_streak < MAXS) m_streak++;
        end
      end else if (!m_acc) begin
        if (mem_req_ready) m_acc = 1;
      end else if (mem_rsp_valid) begin
        m_busy = 0;
        if (m_own_dm) begin ndm = 1; m_dm_d = m_we ? '0 : mem_rsp_data; end
        else          begin nif = 1; m_if_d = mem_rsp_data; end
      end
      m_if_rv = nif;
      m_dm_rv = ndm;
    end
  end

  task automatic drv(input bit ifv, input logic [31:0] ifa, input bit dmv, input logic [31:0] dma,
                     input logic [31:0] wd, input bit we, input logic [2:0] f3,
                     input bit mrdy, input bit mrsp, input logic [31:0] md);
    @(negedge clk);
    if_req_valid = ifv; if_req_addr = ifa;
    dm_req_valid = dmv; dm_req_addr = dma; dm_req_wdata = wd; dm_req_we = we; dm_req_fn3 = f3;
    mem_req_ready = mrdy; mem_rsp_valid = mrsp; mem_rsp_data = md;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
  endtask

  initial begin
    nop(); nop();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_if_ready", if_req_ready, 0);
    chk("rst_dm_ready", dm_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    nop(); rst_n = 1'b1;

    // single fetch, ideal memory
    drv(1, 32'h8000_0000, 0, 0, 0, 0, 3'b000, 0, 0, 0); #2;
    chk("f_c0_if_ready", if_req_ready, 1);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0); #2;
    chk("f_c1_mem_addr", mem_addr, 32'h8000_0000);
    chk("f_c1_mem_fn3", mem_fn3, 3'b010);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'h0050_0093);
    nop(); #2;
    chk("f_c3_rsp_valid", if_rsp_valid, 1);
    chk("f_c3_rsp_data", if_rsp_data, 32'h0050_0093);
    chk("f_c3_dm_rsp", dm_rsp_valid, 0);

    // store then load; load handshake coincides with the store's response pulse
    drv(0, 0, 1, 32'h8000_1000, 32'hDEAD_BEEF, 1, 3'b010, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0); #2;
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'h1234_5678);
    drv(0, 0, 1, 32'h8000_1000, 0, 0, 3'b010, 0, 0, 0); #2;
    chk("st_rsp_valid", dm_rsp_valid, 1);
    chk("st_rsp_data", dm_rsp_data, 0);
    chk("ld_ready", dm_req_ready, 1);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0); #2;
    chk("ld_mem_we", mem_we, 0);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'hDEAD_BEEF);
    nop(); #2;
    chk("ld_rsp_data", dm_rsp_data, 32'hDEAD_BEEF);

    // contention fairness
    grants = "";
    repeat (30) drv(1, 32'h100, 1, 32'h200, 32'h55, 0, 3'b100, 1, 1, 32'hC0DE_0000);
    nop();
    chk_grants("fair_order", "DDDDIDDDDI");

    // memory backpressure
    drv(0, 0, 1, 32'h300, 32'hA5A5_A5A5, 1, 3'b001, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'h777, 1, 32'h999, 32'h1111_1111, 0, 3'b000, 0, 0, 0); #2;
      chk("bp_mem_valid", mem_req_valid, 1);
      chk("bp_mem_addr", mem_addr, 32'h300);
      chk("bp_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("bp_readies", {if_req_ready, dm_req_ready}, 2'b00);
    end
    drv(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'hFFFF_0000);
    nop(); #2;
    chk("bp_rsp_valid", dm_rsp_valid, 1);

    // reset during WAIT (streak raised to 1 first)
    drv(1, 32'h500, 1, 32'h400, 0, 0, 3'b010, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    nop();
    #3 rst_n = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_mem_fn3", mem_fn3, 0);
    chk("rw_if_data", if_rsp_data, 0);
    chk("rw_readies", {if_req_ready, dm_req_ready}, 2'b00);
    nop();
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'hBAD0_BAD0); rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'hBAD0_BAD0); #2;
    chk("rw_no_if_rsp", if_rsp_valid, 0);
    chk("rw_no_dm_rsp", dm_rsp_valid, 0);
    chk("rw_idle", busy, 0);
    grants = "";
    repeat (15) drv(1, 32'h600, 1, 32'h700, 0, 0, 3'b010, 1, 1, 32'h0000_0013);
    nop();
    chk_grants("rw_streak_zero", "DDDDI");

    // spurious response in IDLE
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'hFFFF_FFFF); #2;
      chk("sp_if_rsp", if_rsp_valid, 0);
      chk("sp_dm_rsp", dm_rsp_valid, 0);
      chk("sp_busy", busy, 0);
    end
    nop(); nop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
